// File: rtl/k_means_div_feeder_pkg.sv
// Shared types for the k-means divider feeder.
// Index-width defaults, FSM state encoding and datapath word types.
package kmeansTypes;

    localparam int CLUSTER_BITS_DEF = 3;
    localparam int DIM_BITS_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    typedef logic [63:0] sum_t;
    typedef logic [63:0] count_t;

endpackage

// File: rtl/k_means_sum_ram.sv
// Simple dual-port sum storage: one write port, one registered read.
// No reset; contents survive a reset of the surrounding logic.
module k_means_sum_ram
    import kmeansTypes::*;
#(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    sum_t mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/k_means_div_feeder.sv
// Streams accumulated k-means sums/counts into the divider on flush.
// Optional K_MEANS_DIV_FEEDER_CLEAR_EN zeroes storage as it is streamed.
module k_means_div_feeder
    import kmeansTypes::*;
#(
    parameter int CLUSTER_BITS = CLUSTER_BITS_DEF,
    parameter int DIM_BITS     = DIM_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_operator,
    input  logic [CLUSTER_BITS:0]   num_cluster,
    input  logic [DIM_BITS:0]       data_dim,
    input  logic                    acc_wr_en,
    input  logic [CLUSTER_BITS-1:0] acc_wr_cluster,
    input  logic [DIM_BITS-1:0]     acc_wr_dim,
    input  logic [63:0]             acc_wr_sum,
    input  logic                    cnt_wr_en,
    input  logic [CLUSTER_BITS-1:0] cnt_wr_cluster,
    input  logic [63:0]             cnt_wr_count,
    input  logic                    flush_start,
    output logic                    busy,
    output logic                    flush_done,
    output logic                    wr_drop,
    output logic [63:0]             div_sum,
    output logic [63:0]             div_count,
    output logic                    div_valid,
    output logic                    div_last_dim,
    output logic                    div_last,
    output logic [31:0]             k_means_div_feeder_debug_cnt
);

    localparam int AW = CLUSTER_BITS + DIM_BITS;

    state_t                  state;
    logic [CLUSTER_BITS:0]   nc_q;
    logic [DIM_BITS:0]       dd_q;
    logic [CLUSTER_BITS-1:0] c;
    logic [DIM_BITS-1:0]     d;
    count_t                  cnt_mem [2**CLUSTER_BITS];
    sum_t                    ram_q;
    logic                    idle_wr;
    logic                    idle_cnt_wr;
    logic                    d_last;
    logic                    c_last;
    logic                    ram_we;
    logic [AW-1:0]           ram_waddr;
    sum_t                    ram_wdata;
    logic [31:0]             beat_cnt;

    assign busy        = (state != IDLE);
    assign idle_wr     = rst_n && !busy && acc_wr_en;
    assign idle_cnt_wr = rst_n && !busy && cnt_wr_en;
    assign d_last      = ({1'b0, d} == dd_q - 1'b1);
    assign c_last      = ({1'b0, c} == nc_q - 1'b1);
    assign div_sum     = div_valid ? ram_q : '0;

`ifdef K_MEANS_DIV_FEEDER_CLEAR_EN
    logic          clr_en;
    logic [AW-1:0] clr_addr;

    // Zero each entry one cycle after its read was issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_en   <= 1'b0;
            clr_addr <= '0;
        end else begin
            clr_en   <= (state == READ);
            clr_addr <= {c, d};
        end
    end

    assign ram_we    = idle_wr | clr_en;
    assign ram_waddr = clr_en ? clr_addr : {acc_wr_cluster, acc_wr_dim};
    assign ram_wdata = clr_en ? '0 : acc_wr_sum;

    always_ff @(posedge clk) begin
        if (rst_n && state == DONE) begin
            for (int i = 0; i < 2**CLUSTER_BITS; i++) begin
                cnt_mem[i[CLUSTER_BITS-1:0]] <= '0;
            end
        end else if (idle_cnt_wr) begin
            cnt_mem[cnt_wr_cluster] <= cnt_wr_count;
        end
    end
`else
    assign ram_we    = idle_wr;
    assign ram_waddr = {acc_wr_cluster, acc_wr_dim};
    assign ram_wdata = acc_wr_sum;

    always_ff @(posedge clk) begin
        if (idle_cnt_wr) begin
            cnt_mem[cnt_wr_cluster] <= cnt_wr_count;
        end
    end
`endif

    k_means_sum_ram #(
        .AW(AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (state == READ),
        .raddr ({c, d}),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            nc_q         <= '0;
            dd_q         <= '0;
            c            <= '0;
            d            <= '0;
            div_valid    <= 1'b0;
            div_last_dim <= 1'b0;
            div_last     <= 1'b0;
            div_count    <= '0;
            flush_done   <= 1'b0;
        end else begin
            div_valid    <= 1'b0;
            div_last_dim <= 1'b0;
            div_last     <= 1'b0;
            div_count    <= '0;
            flush_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flush_start) begin
                        nc_q <= num_cluster;
                        dd_q <= data_dim;
                        c    <= '0;
                        d    <= '0;
                        // An empty flush still spends a drain cycle.
                        if (num_cluster == '0 || data_dim == '0) begin
                            state <= DRAIN;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    div_valid    <= 1'b1;
                    div_last_dim <= d_last;
                    div_last     <= d_last && c_last;
                    div_count    <= cnt_mem[c];
                    if (d_last) begin
                        d <= '0;
                        if (c_last) begin
                            state <= DRAIN;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end else begin
                        d <= d + 1'b1;
                    end
                end
                DRAIN: begin
                    state      <= DONE;
                    flush_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_drop <= 1'b0;
        end else if (busy && (acc_wr_en || cnt_wr_en)) begin
            wr_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt                     <= '0;
            k_means_div_feeder_debug_cnt <= '0;
        end else begin
            if (start_operator) begin
                beat_cnt <= '0;
            end else if (div_valid) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            k_means_div_feeder_debug_cnt <= beat_cnt;
        end
    end

endmodule

// File: tb/tb_k_means_div_feeder.sv
// Self-checking bench for k_means_div_feeder.
// Reference model: plain arrays of sums and counts, walked in flush order.
module tb_k_means_div_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_operator;
    logic [3:0]  num_cluster;
    logic [4:0]  data_dim;
    logic        acc_wr_en;
    logic [2:0]  acc_wr_cluster;
    logic [3:0]  acc_wr_dim;
    logic [63:0] acc_wr_sum;
    logic        cnt_wr_en;
    logic [2:0]  cnt_wr_cluster;
    logic [63:0] cnt_wr_count;
    logic        flush_start;
    logic        busy;
    logic        flush_done;
    logic        wr_drop;
    logic [63:0] div_sum;
    logic [63:0] div_count;
    logic        div_valid;
    logic        div_last_dim;
    logic        div_last;
    logic [31:0] dbg;

    int checks = 0;
    int errors = 0;

    logic [63:0] sum_m [8][16];
    logic [63:0] cnt_m [8];

    always #5 clk = ~clk;

    k_means_div_feeder dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .start_operator               (start_operator),
        .num_cluster                  (num_cluster),
        .data_dim                     (data_dim),
        .acc_wr_en                    (acc_wr_en),
        .acc_wr_cluster               (acc_wr_cluster),
        .acc_wr_dim                   (acc_wr_dim),
        .acc_wr_sum                   (acc_wr_sum),
        .cnt_wr_en                    (cnt_wr_en),
        .cnt_wr_cluster               (cnt_wr_cluster),
        .cnt_wr_count                 (cnt_wr_count),
        .flush_start                  (flush_start),
        .busy                         (busy),
        .flush_done                   (flush_done),
        .wr_drop                      (wr_drop),
        .div_sum                      (div_sum),
        .div_count                    (div_count),
        .div_valid                    (div_valid),
        .div_last_dim                 (div_last_dim),
        .div_last                     (div_last),
        .k_means_div_feeder_debug_cnt (dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic wr_sum(input int c, input int d, input logic [63:0] v);
        acc_wr_en      = 1'b1;
        acc_wr_cluster = 3'(c);
        acc_wr_dim     = 4'(d);
        acc_wr_sum     = v;
        sum_m[c][d]    = v;
        step();
        acc_wr_en = 1'b0;
    endtask

    task automatic wr_cnt(input int c, input logic [63:0] v);
        cnt_wr_en      = 1'b1;
        cnt_wr_cluster = 3'(c);
        cnt_wr_count   = v;
        cnt_m[c]       = v;
        step();
        cnt_wr_en = 1'b0;
    endtask

    task automatic fill(input int nc, input int dd);
        for (int c = 0; c < nc; c++) begin
            for (int d = 0; d < dd; d++) wr_sum(c, d, rnd64());
            wr_cnt(c, rnd64());
        end
    endtask

    task automatic run_flush(input int nc, input int dd, input int wr_at,
                             input int fs_at, input int rst_at,
                             input bit simw);
        int n = nc * dd;
        if (simw) begin
            acc_wr_en      = 1'b1;
            acc_wr_cluster = 3'd0;
            acc_wr_dim     = 4'd0;
            acc_wr_sum     = rnd64();
            sum_m[0][0]    = acc_wr_sum;
        end
        num_cluster = 4'(nc);
        data_dim    = 5'(dd);
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        acc_wr_en   = 1'b0;
        chk("busy_c1", busy, 1);
        chk("valid_c1", div_valid, 0);
        for (int i = 0; i < n; i++) begin
            int c = i / dd;
            int d = i % dd;
            step();
            acc_wr_en   = 1'b0;
            cnt_wr_en   = 1'b0;
            flush_start = 1'b0;
            chk($sformatf("valid_%0d", i), div_valid, 1);
            chk($sformatf("sum_%0d", i), div_sum, sum_m[c][d]);
            chk($sformatf("count_%0d", i), div_count, cnt_m[c]);
            chk($sformatf("lastdim_%0d", i), div_last_dim, 64'(d == dd - 1));
            chk($sformatf("last_%0d", i), div_last, 64'(i == n - 1));
            chk($sformatf("done_%0d", i), flush_done, 0);
            if (i == wr_at) begin
                acc_wr_en      = 1'b1;
                acc_wr_cluster = 3'((i + 1) / dd);
                acc_wr_dim     = 4'((i + 1) % dd);
                acc_wr_sum     = rnd64();
                cnt_wr_en      = 1'b1;
                cnt_wr_cluster = 3'(nc - 1);
                cnt_wr_count   = rnd64();
            end
            if (i == fs_at) begin
                flush_start = 1'b1;
                num_cluster = 4'd1;
                data_dim    = 5'd1;
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                chk("rst_valid", div_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_sum", div_sum, 0);
                for (int k = 0; k < 4; k++) begin
                    step();
                    chk("rst_nodone", flush_done, 0);
                    chk("rst_novalid", div_valid, 0);
                end
                return;
            end
        end
        step();
        acc_wr_en   = 1'b0;
        cnt_wr_en   = 1'b0;
        flush_start = 1'b0;
        chk("done_pulse", flush_done, 1);
        chk("done_novalid", div_valid, 0);
        chk("done_busy", busy, 1);
        step();
        chk("done_low", flush_done, 0);
        chk("idle_busy", busy, 0);
`ifdef K_MEANS_DIV_FEEDER_CLEAR_EN
        for (int c = 0; c < nc; c++)
            for (int d = 0; d < dd; d++) sum_m[c][d] = '0;
        for (int c = 0; c < 8; c++) cnt_m[c] = '0;
`endif
    endtask

    initial begin
        rst_n          = 1'b0;
        start_operator = 1'b0;
        num_cluster    = '0;
        data_dim       = '0;
        acc_wr_en      = 1'b0;
        acc_wr_cluster = '0;
        acc_wr_dim     = '0;
        acc_wr_sum     = '0;
        cnt_wr_en      = 1'b0;
        cnt_wr_cluster = '0;
        cnt_wr_count   = '0;
        flush_start    = 1'b0;
        step();
        step();
        chk("rst_busy0", busy, 0);
        chk("rst_done0", flush_done, 0);
        chk("rst_drop0", wr_drop, 0);
        chk("rst_valid0", div_valid, 0);
        chk("rst_sum0", div_sum, 0);
        chk("rst_count0", div_count, 0);
        chk("rst_last0", {62'd0, div_last_dim, div_last}, 0);
        chk("rst_dbg0", dbg, 0);
        rst_n = 1'b1;
        step();

        for (int c = 0; c < 2; c++)
            for (int d = 0; d < 3; d++) wr_sum(c, d, 64'(10 * c + d + 1));
        wr_cnt(0, 64'd4);
        wr_cnt(1, 64'd0);
        start_operator = 1'b1;
        step();
        start_operator = 1'b0;
        run_flush(2, 3, -1, -1, -1, 1'b0);
        chk("dbg_six", dbg, 6);
        start_operator = 1'b1;
        step();
        start_operator = 1'b0;
        step();
        chk("dbg_clear", dbg, 0);

        run_flush(2, 3, -1, -1, -1, 1'b0);
        run_flush(2, 0, -1, -1, -1, 1'b0);
        run_flush(0, 3, -1, -1, -1, 1'b0);
        chk("drop_none", wr_drop, 0);

        fill(3, 4);
        run_flush(3, 4, 2, 4, -1, 1'b0);
        chk("drop_set", wr_drop, 1);

        fill(2, 2);
        run_flush(2, 2, -1, -1, -1, 1'b1);

        for (int r = 0; r < 3; r++) begin
            int nc = $urandom_range(1, 8);
            int dd = $urandom_range(1, 16);
            fill(nc, dd);
            run_flush(nc, dd, -1, -1, -1, 1'b0);
        end
        fill(8, 16);
        run_flush(8, 16, -1, -1, -1, 1'b0);

        fill(2, 3);
        run_flush(2, 3, -1, -1, 2, 1'b0);
        chk("drop_rst", wr_drop, 0);
        chk("dbg_rst", dbg, 0);

        fill(2, 3);
        run_flush(2, 3, -1, -1, -1, 1'b0);
        run_flush(2, 3, -1, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
